phase_accumulator: RTL
======================

# phase_accumulator

Numerically controlled phase stage directly downstream of the FM frequency-word stage. It latches the 24-bit frequency word on a load strobe and accumulates it into an ACC_W-bit phase register. It adds a phase offset and folds the result into a quarter-wave sine LUT address plus sign bit, which feed the sine ROM and DAC formatter. It also emits a one-cycle wrap pulse once per output period.

## Interface
- FW, 24: frequency word width; matches the FM stage output.
- ACC_W, 32: accumulator width; ACC_W ≥ FW. Output frequency = fre × f_clk / 2^ACC_W.
- ADDR_W, 10: quarter-wave LUT address width. Phase resolution is ADDR_W+2 bits.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- en  in  1  advance enable; the accumulator steps only when high.
- fre_load  in  1  capture strobe for fre_in.
- fre_in  in  FW  unsigned frequency word (freFM).
- phase_off  in  ADDR_W+2  unsigned phase offset in full-turn LSBs (2^(ADDR_W+2) = 360°). Sampled every cycle.
- phase_clr  in  1  synchronous accumulator clear.
- addr_out  out  ADDR_W  quarter-wave LUT address.
- sign_out  out  1  1 selects the negative half-cycle.
- valid_out  out  1  addr_out/sign_out correspond to an enabled step.
- wrap  out  1  one-cycle pulse on accumulator carry-out.

## Operation
- Frequency register fre_r (FW bits):
  - Loads fre_in on any cycle with fre_load=1; otherwise holds.
  - Used zero-extended to ACC_W.
  - A word loaded on cycle N is used from the accumulate of cycle N+1; there is no bypass.
- Accumulator acc (ACC_W bits), stage 1. Priority order:
  1. rst_n=0: acc ← 0.
  2. phase_clr=1: acc ← 0, wrap ← 0. Applies regardless of en.
  3. en=1: acc ← (acc + fre_r) mod 2^ACC_W; wrap ← carry-out of that add.
  4. Otherwise: acc holds; wrap ← 0.
- Stage 2 (registered):
  - ph ← (acc[ACC_W-1 -: ADDR_W+2] + phase_off) mod 2^(ADDR_W+2), using acc after the stage-1 update.
  - v2 ← stage-1 valid, where stage-1 valid = the en that caused the update.
- Stage 3 (registered), with q = ph[ADDR_W+1:ADDR_W] and p = ph[ADDR_W-1:0]:
  - addr_out ← q[0] ? ~p : p (mirrored in quarters 1 and 3).
  - sign_out ← q[1].
  - valid_out ← v2.
- fre_r = 0 with en=1: acc constant; valid_out still follows en; wrap never fires.
- phase_off changes take effect with no glitch beyond the one-cycle pipeline delay; there is no smoothing.
- A carry exactly to 0 (e.g. acc = 2^ACC_W − fre_r) counts as a wrap.

## Timing
- Reset values: acc=0, fre_r=0, all pipeline registers 0. Therefore addr_out=0, sign_out=0, valid_out=0, wrap=0.
- Reset mid-stream: on the first cycle after rst_n deasserts, all outputs read reset values. The pipeline refills with 0.
- Latency, en at edge E:
  - acc updates at E; wrap is visible after E.
  - ph registered at E+1.
  - addr_out/sign_out/valid_out registered at E+2.
  - Net: wrap leads the matching addr_out by 2 cycles.
- phase_off sampled at edge E appears on addr_out after E+1.
- Throughput: one phase step per clk while en=1. No backpressure.
- fre_load and phase_clr on the same cycle: both act. acc clears, and the new word is used from the next cycle.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with en=1, fre_in=0x100000, fre_load=1.
  - Response: all outputs 0 throughout. After release, acc starts from 0.
- Linear ramp (ACC_W=32, ADDR_W=10):
  - Stimulus: load fre=0x100000, then en=1 continuously.
  - Response: ph increments by 1 per cycle. addr_out sequence is 0,1,…,1023, then 1023,1022,…,0 with sign_out=0. The next half-cycle repeats with sign_out=1. wrap pulses every 4096 cycles, 2 cycles before addr_out returns to 0 with sign_out=0.
- Offset:
  - Stimulus: same as the ramp, with phase_off=0x400 (90°) from cycle 0.
  - Response: first valid addr_out=1023 mirrored, i.e. ph=0x401 → addr_out=0x3FE, sign_out=0. Throughout, every addr_out equals the ramp value shifted by 1024 steps.
- Frequency hop:
  - Stimulus: fre=0x100000 running; at cycle N pulse fre_load with 0x200000.
  - Response: the acc step changes from 2^20 to 2^21 at edge N+1. ph steps by 2 starting two outputs later. No skipped or repeated sample beyond the step change.
- Enable gating and clear:
  - Stimulus: drop en for 5 cycles, then pulse phase_clr with en=1.
  - Response: during the gap, addr_out is frozen and valid_out=0 (2 cycles delayed). After phase_clr, acc=0 and wrap=0. Two cycles later, addr_out=0, sign_out=0.
- Wrap edge:
  - Stimulus: force acc=0xFFF00000 via a run with fre=0x100000, then take one more step.
  - Response: acc=0, wrap=1 for exactly one cycle. With fre=0 and en=1, wrap stays 0 indefinitely.

Source files
------------

// File: rtl/phase_accumulator.sv
// -----------------------------------------------------------------------------
// phase_accumulator
//
// Phase stage of the NCO. It latches a frequency word and steps an ACC_W-bit
// phase accumulator by that word on every enabled cycle. It adds a phase offset
// to the top ADDR_W+2 bits of the accumulator. It then folds that phase into a
// quarter-wave sine LUT address plus a sign bit for the sine ROM and the DAC
// formatter.
//
// Pipeline:
//   stage 1 : fre_r / acc_r / wrap (carry-out of the add) / stage-1 valid
//   stage 2 : ph_r = top bits of acc_r + phase_off, v2_r
//   stage 3 : addr_out / sign_out / valid_out
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   en         advance enable for the accumulator
//   fre_load   capture strobe for fre_in
//   fre_in     unsigned frequency word (FW bits)
//   phase_off  unsigned phase offset, 2^(ADDR_W+2) LSBs per full turn
//   phase_clr  synchronous accumulator clear (wins over en)
//   addr_out   quarter-wave LUT address
//   sign_out   1 = negative half-cycle
//   valid_out  addr_out/sign_out belong to an enabled step
//   wrap       one-cycle pulse on accumulator carry-out
// -----------------------------------------------------------------------------
module phase_accumulator #(
  parameter int FW     = 24,
  parameter int ACC_W  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fre_load,
  input  logic [FW-1:0]     fre_in,
  input  logic [ADDR_W+1:0] phase_off,
  input  logic              phase_clr,
  output logic [ADDR_W-1:0] addr_out,
  output logic              sign_out,
  output logic              valid_out,
  output logic              wrap
);

  localparam int PH_W = ADDR_W + 2;

  logic [FW-1:0]     fre_r;
  logic [ACC_W-1:0]  acc_r;
  logic              wrap_r;
  logic              v1_r;
  logic [PH_W-1:0]   ph_r;
  logic              v2_r;
  logic [ADDR_W-1:0] addr_r;
  logic              sign_r;
  logic              valid_r;

  logic [ACC_W:0]    sum_s;
  logic [PH_W-1:0]   ph_sum_s;
  logic [ADDR_W-1:0] addr_fold_s;

  // Accumulator add with carry, offset add and quarter-wave fold.
  always_comb begin
    sum_s       = '0;
    ph_sum_s    = '0;
    addr_fold_s = '0;
    // The frequency word is zero-extended. The extra top bit catches the carry-out.
    sum_s    = {1'b0, acc_r} + {{(ACC_W - FW + 1){1'b0}}, fre_r};
    ph_sum_s = acc_r[ACC_W-1 -: PH_W] + phase_off;
    // Quarters 1 and 3 run the LUT backwards.
    if (ph_r[ADDR_W]) begin
      addr_fold_s = ~ph_r[ADDR_W-1:0];
    end else begin
      addr_fold_s = ph_r[ADDR_W-1:0];
    end
  end

  // Stage 1: frequency word, accumulator, wrap pulse and step-valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fre_r  <= '0;
      acc_r  <= '0;
      wrap_r <= 1'b0;
      v1_r   <= 1'b0;
    end else begin
      // A newly loaded word is first added on the following cycle.
      if (fre_load) begin
        fre_r <= fre_in;
      end else begin
        fre_r <= fre_r;
      end
      if (phase_clr) begin
        acc_r  <= '0;
        wrap_r <= 1'b0;
      end else if (en) begin
        acc_r  <= sum_s[ACC_W-1:0];
        wrap_r <= sum_s[ACC_W];
      end else begin
        acc_r  <= acc_r;
        wrap_r <= 1'b0;
      end
      v1_r <= en;
    end
  end

  // Stage 2: offset phase (uses the already-updated accumulator).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_r <= '0;
      v2_r <= 1'b0;
    end else begin
      ph_r <= ph_sum_s;
      v2_r <= v1_r;
    end
  end

  // Stage 3: registered LUT address, sign and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_r  <= '0;
      sign_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      addr_r  <= addr_fold_s;
      sign_r  <= ph_r[ADDR_W+1];
      valid_r <= v2_r;
    end
  end

  assign addr_out  = addr_r;
  assign sign_out  = sign_r;
  assign valid_out = valid_r;
  assign wrap      = wrap_r;

endmodule
